bitserial_alu_seq: RTL and testbench

Multi-cycle bit-serial ALU sequencer: a single one-bit ALU slice is time-shared across all WIDTH bit positions, with operands streamed LSB-first. A running carry is held in a flop between cycles. Sits beside the main ALU in the multi-cycle CPU as a low-area execution unit. It is started by the control FSM and returns a result plus flags after a fixed latency.

---
 rtl/bitserial_alu_seq_if.sv | 26 ++
 rtl/bitserial_alu_seq.sv | 144 ++++++++++++++
 tb/tb_bitserial_alu_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bitserial_alu_seq_if.sv
// Request/response bundle for the bit-serial ALU sequencer.
// The control FSM is the master; the sequencer is the slave.
interface bitserial_alu_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carryout;
   logic             overflow;
   logic             zero;

   modport master (
      output start, op, a, b,
      input  busy, done, result, carryout, overflow, zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, carryout, overflow, zero
   );
endinterface

// File: rtl/bitserial_alu_seq.sv
// Bit-serial ALU sequencer: a single one-bit ALU slice walks the operands LSB-first,
// holding the running carry in a flop, and reports result and flags after WIDTH+1 cycles.
module bitserial_alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic                i_clk,
   input  logic                i_reset,
   bitserial_alu_seq_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_SLT  = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_NAND = 3'd5;
   localparam logic [2:0] OP_NOR  = 3'd6;
   localparam logic [2:0] OP_OR   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIN
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic [2:0]       r_op;
   logic [CW-1:0]    r_count;
   logic             r_carry;
   logic             r_cmsb;
   logic             r_busy;
   logic             r_done;
   logic             r_carryout;
   logic             r_overflow;
   logic             r_zero;

   logic             w_isSub;
   logic             w_isArith;
   logic             w_bBit;
   logic             w_cin;
   logic             w_sum;
   logic             w_cout;
   logic             w_slice;
   logic             w_overflow;
   logic [WIDTH-1:0] w_final;

   // One-bit slice; logic ops see a zero carry-in and use the raw B bit.
   always_comb begin
      w_isSub   = (r_op == OP_SUB) || (r_op == OP_SLT);
      w_isArith = w_isSub || (r_op == OP_ADD);
      w_bBit    = r_b[0] ^ w_isSub;
      w_cin     = r_carry & w_isArith;
      w_sum     = r_a[0] ^ w_bBit ^ w_cin;
      w_cout    = (r_a[0] & w_bBit) | (w_cin & (r_a[0] ^ w_bBit));
      w_slice   = 1'b0;
      case (r_op)
         OP_ADD, OP_SUB, OP_SLT: w_slice = w_sum;
         OP_XOR:                 w_slice = r_a[0] ^ r_b[0];
         OP_AND:                 w_slice = r_a[0] & r_b[0];
         OP_NAND:                w_slice = ~(r_a[0] & r_b[0]);
         OP_NOR:                 w_slice = ~(r_a[0] | r_b[0]);
         OP_OR:                  w_slice = r_a[0] | r_b[0];
         default:                w_slice = 1'b0;
      endcase
   end

   // Signed less-than is the difference's sign corrected by overflow.
   always_comb begin
      w_overflow = w_isArith & (r_cmsb ^ r_carry);
      w_final    = r_result;
      if (r_op == OP_SLT) begin
         w_final = {{(WIDTH-1){1'b0}}, r_result[WIDTH-1] ^ w_overflow};
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state    <= ST_IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_result   <= '0;
         r_op       <= OP_ADD;
         r_count    <= '0;
         r_carry    <= 1'b0;
         r_cmsb     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_carryout <= 1'b0;
         r_overflow <= 1'b0;
         r_zero     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_op    <= bus.op;
                  r_count <= '0;
                  r_carry <= (bus.op == OP_SUB) || (bus.op == OP_SLT);
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_result <= {w_slice, r_result[WIDTH-1:1]};
               r_a      <= {1'b0, r_a[WIDTH-1:1]};
               r_b      <= {1'b0, r_b[WIDTH-1:1]};
               r_carry  <= w_cout;
               r_count  <= r_count + 1'b1;
               if (r_count == CW'(WIDTH-1)) begin
                  r_cmsb  <= w_cin;
                  r_state <= ST_FIN;
               end
            end
            ST_FIN: begin
               r_result   <= w_final;
               r_carryout <= w_isArith & r_carry;
               r_overflow <= w_overflow;
               r_zero     <= (w_final == '0);
               r_done     <= 1'b1;
               r_busy     <= 1'b0;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.result   = r_result;
   assign bus.carryout = r_carryout;
   assign bus.overflow = r_overflow;
   assign bus.zero     = r_zero;
endmodule

// File: tb/tb_bitserial_alu_seq.sv
// Self-checking bench for bitserial_alu_seq: directed and random ops checked
// against an arithmetic reference model, plus protocol and reset scenarios.
module tb_bitserial_alu_seq;
   localparam int WIDTH = 32;
   localparam int LAT   = WIDTH + 1;

   logic clk    = 1'b0;
   logic resetN = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   bitserial_alu_seq_if #(.WIDTH(WIDTH)) bus ();

   bitserial_alu_seq #(.WIDTH(WIDTH)) dut (
      .i_clk   (clk),
      .i_reset (resetN),
      .bus     (bus)
   );

   // Reference behaviour from plain arithmetic on whole words.
   function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic c, output logic v,
                                    output logic z);
      logic [32:0] wide;
      c    = 1'b0;
      v    = 1'b0;
      res  = '0;
      wide = '0;
      case (op)
         3'd0: begin
            wide = {1'b0, a} + {1'b0, b};
            res  = wide[31:0];
            c    = wide[32];
            v    = (a[31] == b[31]) && (res[31] != a[31]);
         end
         3'd1, 3'd3: begin
            wide = {1'b0, a} + {1'b0, ~b} + 33'd1;
            res  = wide[31:0];
            c    = wide[32];
            v    = (a[31] != b[31]) && (res[31] != a[31]);
            if (op == 3'd3) res = {31'b0, ($signed(a) < $signed(b))};
         end
         3'd2: res = a ^ b;
         3'd4: res = a & b;
         3'd5: res = ~(a & b);
         3'd6: res = ~(a | b);
         default: res = a | b;
      endcase
      z = (res == 32'd0);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkFlags(input string tag, input logic [31:0] er, input logic ec,
                             input logic ev, input logic ez);
      checkOutput({tag, " result"},   64'(bus.result),   64'(er));
      checkOutput({tag, " carryout"}, 64'(bus.carryout), 64'(ec));
      checkOutput({tag, " overflow"}, 64'(bus.overflow), 64'(ev));
      checkOutput({tag, " zero"},     64'(bus.zero),     64'(ez));
   endtask

   // Waits at negedges for done, counting edges since acceptance, within a bound.
   task automatic waitDone(input int startCount, output int n);
      n = startCount;
      while (bus.done !== 1'b1 && n < LAT + 10) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input string tag);
      logic [31:0] er;
      logic        ec, ev, ez;
      int          n;
      refModel(op, a, b, er, ec, ev, ez);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.op    = 3'($urandom_range(7, 0));
      checkOutput({tag, " busy"}, 64'(bus.busy), 64'(1));
      waitDone(0, n);
      checkOutput({tag, " latency"}, 64'(n), 64'(LAT));
      checkOutput({tag, " busy@done"}, 64'(bus.busy), 64'(0));
      checkFlags(tag, er, ec, ev, ez);
   endtask

   initial begin
      logic [31:0] er, er2, ra, rb;
      logic        ec, ev, ez, ec2, ev2, ez2;
      logic [2:0]  rop;
      int          n, dones;

      bus.start = 1'b0;
      bus.op    = 3'd0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset busy", 64'(bus.busy), 64'(0));
      checkOutput("reset done", 64'(bus.done), 64'(0));
      checkFlags("reset", 32'd0, 1'b0, 1'b0, 1'b0);
      resetN = 1'b1;

      applyStimulus(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, "add wrap");
      @(negedge clk);
      checkOutput("done pulse width", 64'(bus.done), 64'(0));
      checkOutput("result held idle", 64'(bus.result), 64'(0));
      applyStimulus(3'd1, 32'h8000_0000, 32'h0000_0001, "sub ovf");
      applyStimulus(3'd1, 32'd5, 32'd5, "sub eq");
      applyStimulus(3'd3, 32'hFFFF_FFFB, 32'd3, "slt neg");
      applyStimulus(3'd3, 32'h7FFF_FFFF, 32'h8000_0000, "slt ovf");
      applyStimulus(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, "and");
      applyStimulus(3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, "nand");
      applyStimulus(3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, "or");
      applyStimulus(3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, "nor");
      applyStimulus(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, "xor");
      applyStimulus(3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "and ones");

      for (int i = 0; i < 24; i++) begin
         rop = 3'($urandom_range(7, 0));
         ra  = $urandom;
         rb  = (i % 4 == 0) ? ra : $urandom;
         applyStimulus(rop, ra, rb, "random");
      end

      // Start pulsed mid-run must not disturb the operation in flight.
      refModel(3'd0, 32'h1234_5678, 32'h1111_1111, er, ec, ev, ez);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'h1234_5678; bus.b = 32'h1111_1111;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'hDEAD_BEEF; bus.b = 32'h0BAD_F00D;
      @(negedge clk);
      bus.start = 1'b0;
      waitDone(10, n);
      checkOutput("ignored start latency", 64'(n), 64'(LAT));
      checkFlags("ignored start", er, ec, ev, ez);

      // Start held through done: second op accepted on the edge after done.
      refModel(3'd1, 32'd100, 32'd300, er, ec, ev, ez);
      refModel(3'd7, 32'h00FF_0000, 32'h0000_00F0, er2, ec2, ev2, ez2);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd100; bus.b = 32'd300;
      @(negedge clk);
      bus.op = 3'd7; bus.a = 32'h00FF_0000; bus.b = 32'h0000_00F0;
      waitDone(0, n);
      checkOutput("held latency", 64'(n), 64'(LAT));
      checkOutput("held busy@done", 64'(bus.busy), 64'(0));
      checkFlags("held first", er, ec, ev, ez);
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("held busy after done", 64'(bus.busy), 64'(1));
      checkOutput("held done drop", 64'(bus.done), 64'(0));
      waitDone(0, n);
      checkOutput("held second latency", 64'(n), 64'(LAT));
      checkFlags("held second", er2, ec2, ev2, ez2);

      // Reset mid-run abandons the operation without a done.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'h7777_7777; bus.b = 32'h1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (14) @(negedge clk);
      resetN = 1'b0;
      @(negedge clk);
      checkOutput("midreset busy", 64'(bus.busy), 64'(0));
      checkOutput("midreset done", 64'(bus.done), 64'(0));
      checkFlags("midreset", 32'd0, 1'b0, 1'b0, 1'b0);
      resetN = 1'b1;
      dones = 0;
      repeat (LAT + 5) begin
         @(negedge clk);
         if (bus.done === 1'b1) dones++;
      end
      checkOutput("midreset no done", 64'(dones), 64'(0));
      applyStimulus(3'd0, 32'd2, 32'd3, "post reset add");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
